// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8x16 register file, A/B operand registers, B-path shifter and ALU operand muxes.
// Build option: define OPF_WRITE_BYPASS_EN to let a same-cycle write to the read index flow straight into A/B.
module operand_fetch #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              write,
   input  logic [2:0]        writenum,
   input  logic              vsel,
   input  logic [DATA_W-1:0] datapath_in,
   input  logic [DATA_W-1:0] C_in,
   input  logic [2:0]        readnum,
   input  logic              loada,
   input  logic              loadb,
   input  logic [1:0]        shift,
   input  logic              asel,
   input  logic              bsel,
   input  logic [DATA_W-1:0] sximm5,
   output logic [DATA_W-1:0] Ain,
   output logic [DATA_W-1:0] Bin,
   output logic              ops_valid
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] b_shifted;
   logic              a_ld;
   logic              b_ld;

   assign write_data = vsel ? datapath_in : C_in;
   assign read_data  = regs[readnum];

`ifdef OPF_WRITE_BYPASS_EN
   // Write-through: a load from the index being written sees the new value this edge.
   assign load_data = (write && (writenum == readnum)) ? write_data : read_data;
`else
   assign load_data = read_data;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write) begin
         regs[writenum] <= write_data;
      end
   end

   // a_ld/b_ld are sticky: once an operand has been captured it stays valid until reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_reg <= '0;
         b_reg <= '0;
         a_ld  <= 1'b0;
         b_ld  <= 1'b0;
      end else begin
         if (loada) begin
            a_reg <= load_data;
            a_ld  <= 1'b1;
         end
         if (loadb) begin
            b_reg <= load_data;
            b_ld  <= 1'b1;
         end
      end
   end

   always_comb begin
      b_shifted = b_reg;
      case (shift)
         2'b00: b_shifted = b_reg;
         2'b01: b_shifted = {b_reg[DATA_W-2:0], 1'b0};
         2'b10: b_shifted = {1'b0, b_reg[DATA_W-1:1]};
         2'b11: b_shifted = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
         default: b_shifted = b_reg;
      endcase
   end

   assign Ain       = asel ? '0 : a_reg;
   assign Bin       = bsel ? sximm5 : b_shifted;
   assign ops_valid = a_ld & b_ld;

endmodule
